// File: rtl/coil_bridge_model_if.sv
// Bridge-gate and coil-observation bundle between the stepper/chopper side and the coil model.
// The model owns the slave side: it sees the gates and drives the current, mode, trip and fault.
interface coil_bridge_model_if #(
  parameter int NUM_COILS = 2,
  parameter int CUR_W     = 13
);
  logic [NUM_COILS-1:0]       s_l1;
  logic [NUM_COILS-1:0]       s_h1;
  logic [NUM_COILS-1:0]       s_l2;
  logic [NUM_COILS-1:0]       s_h2;
  logic                       fault_clr;
  logic [CUR_W-2:0]           vref;
  logic [NUM_COILS*CUR_W-1:0] current;
  logic [NUM_COILS*3-1:0]     mode;
  logic [NUM_COILS-1:0]       trip;
  logic [NUM_COILS-1:0]       fault;

  modport master (
    output s_l1, s_h1, s_l2, s_h2, fault_clr, vref,
    input  current, mode, trip, fault
  );

  modport slave (
    input  s_l1, s_h1, s_l2, s_h2, fault_clr, vref,
    output current, mode, trip, fault
  );
endinterface

// File: rtl/coil_bridge_model.sv
// Behavioural model of NUM_COILS H-bridge-driven coils: gate decode, ramped current
// integration with saturation, latched shoot-through fault and registered trip comparator.
module coil_bridge_model #(
  parameter int NUM_COILS = 2,
  parameter int CUR_W     = 13,
  parameter int IMAX      = 4095,
  parameter int RISE_STEP = 4,
  parameter int SLOW_STEP = 1,
  parameter int FAST_STEP = 8,
  parameter int PRESCALE  = 1
) (
  input logic                clk,
  input logic                resetn,
  coil_bridge_model_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_FWD   = 3'd1,
    MODE_REV   = 3'd2,
    MODE_SLOW  = 3'd3,
    MODE_SHOOT = 3'd4
  } mode_e;

  // One bit of headroom so a step past IMAX can be detected before clamping.
  typedef logic signed [CUR_W:0] wide_t;
  typedef logic signed [CUR_W-1:0] cur_t;

  localparam wide_t P_IMAX = wide_t'(IMAX);
  localparam wide_t P_RISE = wide_t'(RISE_STEP);
  localparam wide_t P_SLOW = wide_t'(SLOW_STEP);
  localparam wide_t P_FAST = wide_t'(FAST_STEP);
  localparam int    PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]      r_presc;
  logic                 w_tick;
  mode_e                r_mode [NUM_COILS];
  mode_e                w_mode [NUM_COILS];
  cur_t                 r_cur  [NUM_COILS];
  cur_t                 w_cur_next [NUM_COILS];
  logic [NUM_COILS-1:0] r_trip;
  logic [NUM_COILS-1:0] r_fault;

  function automatic mode_e decode(input logic h1, input logic l1,
                                   input logic h2, input logic l2);
    if ((h1 & l1) | (h2 & l2))                         return MODE_SHOOT;
    else if (h1 & l2 & ~h2 & ~l1)                      return MODE_FWD;
    else if (h2 & l1 & ~h1 & ~l2)                      return MODE_REV;
    else if ((l1 & l2 & ~h1 & ~h2) | (h1 & h2 & ~l1 & ~l2)) return MODE_SLOW;
    else                                               return MODE_OFF;
  endfunction

  // Moves toward zero without crossing it.
  function automatic wide_t decay(input wide_t c, input wide_t step);
    if (c > step)       return c - step;
    else if (c < -step) return c + step;
    else                return '0;
  endfunction

  function automatic cur_t step_current(input mode_e m, input cur_t c);
    wide_t ext;
    wide_t nxt;
    ext = wide_t'(c);
    nxt = ext;
    case (m)
      MODE_FWD:  nxt = (ext + P_RISE > P_IMAX)  ?  P_IMAX : ext + P_RISE;
      MODE_REV:  nxt = (ext - P_RISE < -P_IMAX) ? -P_IMAX : ext - P_RISE;
      MODE_SLOW: nxt = decay(ext, P_SLOW);
      MODE_OFF:  nxt = decay(ext, P_FAST);
      default:   nxt = ext;
    endcase
    return nxt[CUR_W-1:0];
  endfunction

  function automatic logic [CUR_W:0] magnitude(input cur_t c);
    wide_t ext;
    ext = wide_t'(c);
    return (ext < 0) ? $unsigned(-ext) : $unsigned(ext);
  endfunction

  assign w_tick = (r_presc == PS_W'(PRESCALE - 1));

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < NUM_COILS; i++) begin
      w_mode[i]     = decode(bus.s_h1[i], bus.s_l1[i], bus.s_h2[i], bus.s_l2[i]);
      w_cur_next[i] = w_tick ? step_current(w_mode[i], r_cur[i]) : r_cur[i];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_presc <= '0;
      r_trip  <= '0;
      r_fault <= '0;
      for (int i = 0; i < NUM_COILS; i++) begin
        r_mode[i] <= MODE_OFF;
        r_cur[i]  <= '0;
      end
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
      for (int i = 0; i < NUM_COILS; i++) begin
        r_mode[i]  <= w_mode[i];
        r_cur[i]   <= w_cur_next[i];
        r_trip[i]  <= (magnitude(r_cur[i]) >= {2'b00, bus.vref});
        // Set dominates clear so a fault cannot be cleared while the bridge still shoots through.
        r_fault[i] <= (w_mode[i] == MODE_SHOOT) | (r_fault[i] & ~bus.fault_clr);
      end
    end
  end

  for (genvar g = 0; g < NUM_COILS; g++) begin : g_out
    assign bus.current[g*CUR_W +: CUR_W] = r_cur[g];
    assign bus.mode[g*3 +: 3]            = r_mode[g];
  end

  assign bus.trip  = r_trip;
  assign bus.fault = r_fault;

endmodule

// File: tb/tb_coil_bridge_model.sv
// Directed bench for coil_bridge_model: one instance at PRESCALE=1 for ramps, decay,
// reversal and faults, a second at PRESCALE=4 for tick spacing and the trip comparator.
module tb_coil_bridge_model;

  localparam int NC = 2;
  localparam int CW = 13;

  logic clk;
  logic resetn;
  int   pass_cnt;
  int   chk_cnt;

  coil_bridge_model_if #(.NUM_COILS(NC), .CUR_W(CW)) bus_a ();
  coil_bridge_model_if #(.NUM_COILS(NC), .CUR_W(CW)) bus_b ();

  coil_bridge_model #(.NUM_COILS(NC), .CUR_W(CW), .PRESCALE(1)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a)
  );

  coil_bridge_model #(.NUM_COILS(NC), .CUR_W(CW), .PRESCALE(4)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cur_a(input int c);
    logic signed [CW-1:0] v;
    v = bus_a.current[c*CW +: CW];
    return int'(v);
  endfunction

  function automatic int cur_b(input int c);
    logic signed [CW-1:0] v;
    v = bus_b.current[c*CW +: CW];
    return int'(v);
  endfunction

  function automatic int mode_a(input int c);
    return int'(bus_a.mode[c*3 +: 3]);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gates_a(input int c, input logic h1, input logic l1,
                         input logic h2, input logic l2);
    bus_a.s_h1[c] = h1;
    bus_a.s_l1[c] = l1;
    bus_a.s_h2[c] = h2;
    bus_a.s_l2[c] = l2;
  endtask

  task automatic idle_all();
    bus_a.s_h1 = '0; bus_a.s_l1 = '0; bus_a.s_h2 = '0; bus_a.s_l2 = '0;
    bus_b.s_h1 = '0; bus_b.s_l1 = '0; bus_b.s_h2 = '0; bus_b.s_l2 = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_all();
    bus_a.fault_clr = 1'b0;
    cyc(2);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_a.s_h1 = NC'($urandom); bus_a.s_l1 = NC'($urandom);
      bus_a.s_h2 = NC'($urandom); bus_a.s_l2 = NC'($urandom);
      cyc(1);
    end
    chk_cnt++; if (bus_a.current !== '0) $display("FAIL reset_current: got %h want 0", bus_a.current); else pass_cnt++;
    chk_cnt++; if (bus_a.mode !== '0) $display("FAIL reset_mode: got %h want 0", bus_a.mode); else pass_cnt++;
    chk_cnt++; if (bus_a.trip !== '0) $display("FAIL reset_trip: got %b want 00", bus_a.trip); else pass_cnt++;
    chk_cnt++; if (bus_a.fault !== '0) $display("FAIL reset_fault: got %b want 00", bus_a.fault); else pass_cnt++;
    idle_all();
    resetn = 1'b1;
    bus_a.vref = '0;
    cyc(1);
    chk_cnt++; if (bus_a.trip !== 2'b11) $display("FAIL vref0_trip: got %b want 11", bus_a.trip); else pass_cnt++;
    bus_a.vref = 12'd4095;
  endtask

  task automatic test_fwd_ramp();
    do_reset();
    gates_a(0, 1, 0, 0, 1);
    cyc(1);
    chk_cnt++; if (mode_a(0) !== 1) $display("FAIL fwd_mode: got %0d want 1", mode_a(0)); else pass_cnt++;
    chk_cnt++; if (cur_a(0) !== 4) $display("FAIL fwd_first: got %0d want 4", cur_a(0)); else pass_cnt++;
    cyc(9);
    chk_cnt++; if (cur_a(0) !== 40) $display("FAIL fwd_10: got %0d want 40", cur_a(0)); else pass_cnt++;
    cyc(1100);
    chk_cnt++; if (cur_a(0) !== 4095) $display("FAIL fwd_sat: got %0d want 4095", cur_a(0)); else pass_cnt++;
    cyc(5);
    chk_cnt++; if (cur_a(0) !== 4095) $display("FAIL fwd_sat_hold: got %0d want 4095", cur_a(0)); else pass_cnt++;
    chk_cnt++; if (cur_a(1) !== 0) $display("FAIL fwd_coil1: got %0d want 0", cur_a(1)); else pass_cnt++;
  endtask

  task automatic test_decay();
    do_reset();
    gates_a(0, 1, 0, 0, 1);
    cyc(10);
    gates_a(0, 0, 1, 0, 1);
    cyc(1);
    chk_cnt++; if (cur_a(0) !== 39) $display("FAIL slow_1: got %0d want 39", cur_a(0)); else pass_cnt++;
    chk_cnt++; if (mode_a(0) !== 3) $display("FAIL slow_mode: got %0d want 3", mode_a(0)); else pass_cnt++;
    cyc(38);
    chk_cnt++; if (cur_a(0) !== 1) $display("FAIL slow_39: got %0d want 1", cur_a(0)); else pass_cnt++;
    cyc(5);
    chk_cnt++; if (cur_a(0) !== 0) $display("FAIL slow_zero: got %0d want 0", cur_a(0)); else pass_cnt++;

    do_reset();
    gates_a(0, 1, 0, 0, 1);
    cyc(10);
    gates_a(0, 0, 0, 0, 0);
    cyc(1);
    chk_cnt++; if (cur_a(0) !== 32) $display("FAIL off_1: got %0d want 32", cur_a(0)); else pass_cnt++;
    cyc(3);
    chk_cnt++; if (cur_a(0) !== 8) $display("FAIL off_4: got %0d want 8", cur_a(0)); else pass_cnt++;
    cyc(4);
    chk_cnt++; if (cur_a(0) !== 0) $display("FAIL off_zero: got %0d want 0", cur_a(0)); else pass_cnt++;

    do_reset();
    gates_a(0, 1, 0, 0, 1);
    cyc(2);
    gates_a(0, 0, 1, 0, 1);
    cyc(3);
    chk_cnt++; if (cur_a(0) !== 5) $display("FAIL off5_setup: got %0d want 5", cur_a(0)); else pass_cnt++;
    gates_a(0, 0, 0, 0, 0);
    cyc(1);
    chk_cnt++; if (cur_a(0) !== 0) $display("FAIL off5_clamp: got %0d want 0", cur_a(0)); else pass_cnt++;
    cyc(2);
    chk_cnt++; if (cur_a(0) !== 0) $display("FAIL off5_hold: got %0d want 0", cur_a(0)); else pass_cnt++;
  endtask

  task automatic test_reversal();
    do_reset();
    gates_a(0, 1, 0, 0, 1);
    cyc(2);
    gates_a(0, 0, 1, 1, 0);
    cyc(1);
    chk_cnt++; if (cur_a(0) !== 4) $display("FAIL rev_1: got %0d want 4", cur_a(0)); else pass_cnt++;
    chk_cnt++; if (mode_a(0) !== 2) $display("FAIL rev_mode: got %0d want 2", mode_a(0)); else pass_cnt++;
    cyc(2);
    chk_cnt++; if (cur_a(0) !== -4) $display("FAIL rev_cross: got %0d want -4", cur_a(0)); else pass_cnt++;
    cyc(1100);
    chk_cnt++; if (cur_a(0) !== -4095) $display("FAIL rev_sat: got %0d want -4095", cur_a(0)); else pass_cnt++;
    chk_cnt++; if (cur_a(1) !== 0) $display("FAIL rev_coil1: got %0d want 0", cur_a(1)); else pass_cnt++;
  endtask

  task automatic test_shoot_through();
    do_reset();
    gates_a(1, 1, 0, 0, 1);
    cyc(3);
    chk_cnt++; if (cur_a(1) !== 12) $display("FAIL shoot_setup: got %0d want 12", cur_a(1)); else pass_cnt++;
    gates_a(1, 1, 1, 0, 0);
    cyc(1);
    chk_cnt++; if (bus_a.fault !== 2'b10) $display("FAIL shoot_fault: got %b want 10", bus_a.fault); else pass_cnt++;
    chk_cnt++; if (mode_a(1) !== 4) $display("FAIL shoot_mode: got %0d want 4", mode_a(1)); else pass_cnt++;
    chk_cnt++; if (cur_a(1) !== 12) $display("FAIL shoot_hold: got %0d want 12", cur_a(1)); else pass_cnt++;
    bus_a.fault_clr = 1'b1;
    cyc(2);
    chk_cnt++; if (bus_a.fault !== 2'b10) $display("FAIL shoot_clr_blocked: got %b want 10", bus_a.fault); else pass_cnt++;
    chk_cnt++; if (cur_a(1) !== 12) $display("FAIL shoot_hold2: got %0d want 12", cur_a(1)); else pass_cnt++;
    bus_a.fault_clr = 1'b0;
    gates_a(1, 0, 0, 0, 0);
    cyc(1);
    chk_cnt++; if (bus_a.fault !== 2'b10) $display("FAIL shoot_sticky: got %b want 10", bus_a.fault); else pass_cnt++;
    bus_a.fault_clr = 1'b1;
    cyc(1);
    chk_cnt++; if (bus_a.fault !== 2'b00) $display("FAIL shoot_cleared: got %b want 00", bus_a.fault); else pass_cnt++;
    bus_a.fault_clr = 1'b0;
  endtask

  task automatic test_trip_prescale();
    do_reset();
    bus_b.s_h1[0] = 1'b1;
    bus_b.s_l2[0] = 1'b1;
    cyc(3);
    chk_cnt++; if (cur_b(0) !== 0) $display("FAIL ps_wait: got %0d want 0", cur_b(0)); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (cur_b(0) !== 4) $display("FAIL ps_tick1: got %0d want 4", cur_b(0)); else pass_cnt++;
    cyc(15);
    chk_cnt++; if (cur_b(0) !== 16) $display("FAIL ps_tick4: got %0d want 16", cur_b(0)); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (cur_b(0) !== 20) $display("FAIL ps_tick5: got %0d want 20", cur_b(0)); else pass_cnt++;
    chk_cnt++; if (bus_b.trip[0] !== 1'b0) $display("FAIL trip_lag: got %b want 0", bus_b.trip[0]); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (bus_b.trip[0] !== 1'b1) $display("FAIL trip_pos: got %b want 1", bus_b.trip[0]); else pass_cnt++;
    bus_b.s_h1[0] = 1'b0;
    bus_b.s_l2[0] = 1'b0;
    bus_b.s_h2[0] = 1'b1;
    bus_b.s_l1[0] = 1'b1;
    cyc(3);
    chk_cnt++; if (cur_b(0) !== 16) $display("FAIL rev_ps_1: got %0d want 16", cur_b(0)); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (bus_b.trip[0] !== 1'b0) $display("FAIL trip_drop: got %b want 0", bus_b.trip[0]); else pass_cnt++;
    cyc(35);
    chk_cnt++; if (cur_b(0) !== -20) $display("FAIL rev_ps_neg: got %0d want -20", cur_b(0)); else pass_cnt++;
    chk_cnt++; if (bus_b.trip[0] !== 1'b0) $display("FAIL trip_neg_lag: got %b want 0", bus_b.trip[0]); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (bus_b.trip[0] !== 1'b1) $display("FAIL trip_neg: got %b want 1", bus_b.trip[0]); else pass_cnt++;
  endtask

  initial begin
    pass_cnt        = 0;
    chk_cnt         = 0;
    resetn          = 1'b0;
    bus_a.fault_clr = 1'b0;
    bus_b.fault_clr = 1'b0;
    bus_a.vref      = 12'd4095;
    bus_b.vref      = 12'd20;
    idle_all();

    test_reset();
    test_fwd_ramp();
    test_decay();
    test_reversal();
    test_shoot_through();
    test_trip_prescale();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
